// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared types for the data-memory bus arbiter: FSM states, owner encoding and
// the registered request payload.
package dmem_bus_arbiter_pkg;

    // Widths the payload struct is built for; the top checks its parameters match.
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;
    localparam int REQ_STRB_W = REQ_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    typedef enum logic {
        M0,
        M1
    } owner_t;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic [REQ_STRB_W-1:0] strb;
    } req_t;

    // The master that gets priority after the given one has been served.
    function automatic owner_t other_owner(input owner_t o);
        return (o == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Combinational 2-way round-robin picker. rr_ptr only matters on a tie;
// a lone requester always wins.
module dmem_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] grant,
    output logic       winner
);

    // Resolve the winner, then expand it to a one-hot grant when anyone asks.
    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = rr_ptr;
            default: winner = 1'b0;
        endcase
        if (req != 2'b00) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the single data-memory port (M0 = LSU, M1 = debug/DMA).
// One transaction in flight: IDLE -> XFER -> RESP -> IDLE, round-robin on ties.
// Optional watchdog on XFER enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_bus_arbiter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_strb,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_strb,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,

    output logic                s_valid,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_strb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata
);

    // The payload struct has fixed widths; catch a mismatched instantiation early.
    if (ADDR_W != REQ_ADDR_W || DATA_W != REQ_DATA_W) begin : g_width_check
        $error("dmem_bus_arbiter: ADDR_W/DATA_W must match the payload struct widths");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("dmem_bus_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    state_t              state_q;
    owner_t              owner_q;
    owner_t              rr_ptr_q;
    req_t                payload_q;
    logic                s_valid_q;
    logic [1:0]          ack_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [1:0]          grant;
    logic                winner;
    req_t                payload_d;

    dmem_arb_rr_pick u_rr_pick (
        .req    ({m1_req, m0_req}),
        .rr_ptr (rr_ptr_q),
        .grant  (grant),
        .winner (winner)
    );

    // Select the granted master's payload for capture in IDLE.
    always_comb begin
        if (grant[1]) begin
            payload_d = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, strb: m1_strb};
        end else begin
            payload_d = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, strb: m0_strb};
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    // Arbitration FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= M0;
            rr_ptr_q  <= M0;
            payload_q <= '0;
            s_valid_q <= 1'b0;
            ack_q     <= 2'b00;
            rdata_q   <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        payload_q <= payload_d;
                        owner_q   <= owner_t'(winner);
                        s_valid_q <= 1'b1;
`ifdef DMEM_ARB_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                        state_q   <= XFER;
                    end
                end
                XFER: begin
                    if (s_ready) begin
                        // Writes return zero so the requester never sees stale data.
                        rdata_q   <= payload_q.we ? '0 : s_rdata;
                        ack_q     <= (owner_q == M1) ? 2'b10 : 2'b01;
                        s_valid_q <= 1'b0;
                        state_q   <= RESP;
`ifdef DMEM_ARB_TIMEOUT_EN
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        ack_q     <= (owner_q == M1) ? 2'b10 : 2'b01;
                        s_valid_q <= 1'b0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    ack_q    <= 2'b00;
                    rdata_q  <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
                    err_q    <= 1'b0;
`endif
                    rr_ptr_q <= other_owner(owner_q);
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_valid  = s_valid_q;
    assign s_we     = payload_q.we;
    assign s_addr   = payload_q.addr;
    assign s_wdata  = payload_q.wdata;
    assign s_strb   = payload_q.strb;

    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_rdata = ack_q[0] ? rdata_q : '0;
    assign m1_rdata = ack_q[1] ? rdata_q : '0;

`ifdef DMEM_ARB_TIMEOUT_EN
    assign m0_err   = ack_q[0] & err_q;
    assign m1_err   = ack_q[1] & err_q;
`else
    assign m0_err   = 1'b0;
    assign m1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed self-checking bench for dmem_bus_arbiter. Inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_dmem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_strb, m1_strb;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_we, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_strb;

    int n_cmp;
    int n_bad;

    dmem_bus_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_strb  (m0_strb),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_strb  (m1_strb),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .s_valid  (s_valid),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_strb   (s_strb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Safety net in case the sequence wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_strb = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_strb = 0;
        s_ready = 0; s_rdata = 0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_svalid", 32'(s_valid), 0);
        check("rst_acks", 32'({m1_ack, m0_ack}), 0);
        check("rst_saddr", s_addr, 0);

        // M0 read with two wait cycles
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_svalid", 32'(s_valid), 1);
            check("rd_noack", 32'({m1_ack, m0_ack}), 0);
            if (i == 2) begin
                s_ready = 1; s_rdata = 32'hDEAD_BEEF;
            end
        end
        check("rd_saddr", s_addr, 32'h0000_0100);
        check("rd_swe", 32'(s_we), 0);
        tick();
        check("rd_svalid_resp", 32'(s_valid), 0);
        check("rd_m0ack", 32'(m0_ack), 1);
        check("rd_m0rdata", m0_rdata, 32'hDEAD_BEEF);
        check("rd_m0err", 32'(m0_err), 0);
        check("rd_m1ack", 32'(m1_ack), 0);
        check("rd_m1rdata", m1_rdata, 0);
        s_ready = 0; s_rdata = 0;
        tick();
        m0_req = 0;
        check("rd_ack_gone", 32'(m0_ack), 0);
        check("rd_rdata_gone", m0_rdata, 0);

        // Reset mid-XFER while rr_ptr points at M1
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_0040; m1_wdata = 32'h1; m1_strb = 4'hF;
        tick();
        check("rstx_svalid_pre", 32'(s_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstx_svalid", 32'(s_valid), 0);
        check("rstx_acks", 32'({m1_ack, m0_ack}), 0);
        m1_req = 0;
        tick();
        rst_n = 1'b1;

        // Tie with s_ready always high: grants alternate starting at M0
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_00A0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h0000_00B0;
        s_ready = 1;
        for (int k = 0; k < 4; k++) begin
            s_rdata = 32'h1000 + k;
            tick();
            check("tie_svalid", 32'(s_valid), 1);
            check("tie_saddr", s_addr, (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B0);
            tick();
            check("tie_m0ack", 32'(m0_ack), (k % 2 == 0) ? 1 : 0);
            check("tie_m1ack", 32'(m1_ack), (k % 2 == 0) ? 0 : 1);
            check("tie_rdata", (k % 2 == 0) ? m0_rdata : m1_rdata, 32'h1000 + k);
            tick();
            check("tie_idle_acks", 32'({m1_ack, m0_ack}), 0);
            check("tie_idle_svalid", 32'(s_valid), 0);
        end
        m0_req = 0; m1_req = 0; s_ready = 0;
        tick();

        // M1 write while rr_ptr points at M0: lone requester still wins
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_0010; m1_wdata = 32'h1234_5678;
        m1_strb = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wr_svalid", 32'(s_valid), 1);
            check("wr_swe", 32'(s_we), 1);
            check("wr_saddr", s_addr, 32'h0000_0010);
            check("wr_swdata", s_wdata, 32'h1234_5678);
            check("wr_sstrb", 32'(s_strb), 32'h6);
        end
        s_ready = 1; s_rdata = 32'hFFFF_FFFF;
        tick();
        check("wr_m1ack", 32'(m1_ack), 1);
        check("wr_m1rdata", m1_rdata, 0);
        check("wr_m0ack", 32'(m0_ack), 0);
        s_ready = 0; s_rdata = 0;
        tick();
        m1_req = 0;

        // Owner drops req during XFER
        begin
            int acks;
            acks = 0;
            m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0200;
            tick();
            check("drop_svalid", 32'(s_valid), 1);
            m0_req = 0;
            tick();
            check("drop_svalid_hold", 32'(s_valid), 1);
            s_ready = 1; s_rdata = 32'hCAFE_F00D;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (i == 0) begin
                    check("drop_rdata", m0_rdata, 32'hCAFE_F00D);
                    s_ready = 0; s_rdata = 0;
                end
                if (m0_ack) acks++;
                if (i >= 2) check("drop_no_regrant", 32'(s_valid), 0);
            end
            check("drop_ack_count", acks, 1);
        end

`ifdef DMEM_ARB_TIMEOUT_EN
        // Watchdog: no s_ready -> abort after exactly 4 XFER cycles
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0300; s_rdata = 32'hAAAA_5555;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_svalid", 32'(s_valid), 1);
        end
        tick();
        check("to_svalid_drop", 32'(s_valid), 0);
        check("to_m0ack", 32'(m0_ack), 1);
        check("to_m0err", 32'(m0_err), 1);
        check("to_m0rdata", m0_rdata, 0);
        tick();
        m0_req = 0;
        check("to_err_gone", 32'(m0_err), 0);
        tick();

        // s_ready on the last allowed cycle beats the timeout
        m0_req = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tor_svalid", 32'(s_valid), 1);
        end
        s_ready = 1; s_rdata = 32'h0000_55AA;
        tick();
        check("tor_m0ack", 32'(m0_ack), 1);
        check("tor_m0err", 32'(m0_err), 0);
        check("tor_m0rdata", m0_rdata, 32'h0000_55AA);
        s_ready = 0;
        tick();
        m0_req = 0;
`else
        // No watchdog: XFER waits well past TIMEOUT_CYCLES and never errors
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0300;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("nto_svalid", 32'(s_valid), 1);
            check("nto_noack", 32'(m0_ack), 0);
        end
        s_ready = 1; s_rdata = 32'h0000_55AA;
        tick();
        check("nto_m0ack", 32'(m0_ack), 1);
        check("nto_m0err", 32'(m0_err), 0);
        check("nto_m0rdata", m0_rdata, 32'h0000_55AA);
        s_ready = 0;
        tick();
        m0_req = 0;
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
